memc_block_scheduler: RTL and testbench
=======================================

# memc_block_scheduler

Block-level sequencer for the inter-prediction MEMC engine. Walks the 80×45 grid of block slots in raster order for a programmable number of passes. For each slot it:
- fetches the 128-lane × 16-bit measurement vector from slot memory,
- presents it on the engine's streaming input with ROWS/COLUMNS,
- waits for the engine's FINISH_FLAG rising edge,
- writes the engine's streaming output back to reconstruction memory.

It sits between the slot/reconstruction memories and the MEMC top, replacing bench-driven sequencing in the synthesizable system.

## Interface
Parameters:
- BLK_COLS, 80, block columns per frame
- BLK_ROWS, 45, block rows per frame
- LANES, 128, 16-bit lanes on the streaming buses
- DW, 16, lane width
- NUM_PASSES, 2, full-frame passes per START
- TIMEOUT, 65535, max cycles in RUN before ERROR

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  one-cycle start pulse, honoured only in IDLE
- MODE  in  2  00: 64 active lanes; 01: 128 active lanes; 10/11: illegal
- RD_REQ  out  1  slot-memory read request
- RD_ADDR  out  12  slot index = row*BLK_COLS + col, range 0..3599
- RD_VALID  in  1  read data valid
- RD_DATA  in  LANES*DW  slot vector, lane k at [DW*k +: DW]
- COLUMNS  out  8  current block column to engine
- ROWS  out  8  current block row to engine
- STREAMING_Y_IN  out  LANES*DW  vector to engine
- BLK_VALID  out  1  high while a block is presented to the engine
- FINISH_FLAG  in  1  engine completion; only its rising edge is used
- STREAMING_Y_OUT  in  LANES*DW  engine result
- WR_EN  out  1  one-cycle writeback strobe
- WR_ADDR  out  12  same slot index as the fetch
- WR_PASS  out  1  pass number of the writeback (LSB)
- WR_DATA  out  LANES*DW  masked engine result
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse after the last writeback of the last pass
- ERROR  out  1  sticky; cleared only by RST or an accepted START

## Operation
- States: IDLE, FETCH, RUN, WB, ADV.
- IDLE → FETCH on START with MODE ∈ {00, 01}:
  - clears col, row, pass and ERROR;
  - latches MODE, so later MODE changes are ignored until the next START.
- IDLE on START with MODE ∈ {10, 11}: sets ERROR and stays in IDLE.
- FETCH:
  - RD_REQ held high and RD_ADDR held stable until RD_VALID.
  - On RD_VALID, capture RD_DATA into STREAMING_Y_IN with inactive lanes forced to 0 (MODE 00: lanes 64..127 zero). Go to RUN.
- RUN:
  - BLK_VALID high; COLUMNS, ROWS and STREAMING_Y_IN held constant.
  - finish_d register samples FINISH_FLAG every cycle. rise = FINISH_FLAG & ~finish_d.
  - On rise → WB.
  - A FINISH_FLAG already high on RUN entry is not a rise; the engine must drop and re-raise it.
- RUN timeout: a watchdog counts RUN cycles. On reaching TIMEOUT:
  - set ERROR;
  - abandon the block, with no writeback;
  - go to ADV.
- WB: WR_EN=1 for one cycle with WR_DATA = STREAMING_Y_OUT masked as in FETCH, WR_ADDR = current slot, WR_PASS = pass. Then → ADV.
- ADV advances position and decides the next state:
  - col = col+1;
  - if col == BLK_COLS-1, col=0 and row=row+1;
  - if row == BLK_ROWS-1 also, row=0 and pass=pass+1;
  - if pass == NUM_PASSES-1 also → IDLE with DONE pulse;
  - otherwise → FETCH.
- RD_ADDR arithmetic: 12-bit unsigned, row*BLK_COLS + col. Held in an incrementing counter, reset to 0 at each pass wrap.
- START while BUSY is ignored.

## Timing
- Reset values:
  - state=IDLE;
  - RD_REQ, BLK_VALID, WR_EN, BUSY, DONE, ERROR = 0;
  - COLUMNS, ROWS, RD_ADDR, WR_ADDR, WR_PASS = 0;
  - STREAMING_Y_IN, WR_DATA = 0;
  - finish_d = 0.
- START accepted at edge N: BUSY and RD_REQ high from N+1.
- RD_VALID sampled at edge M: BLK_VALID and the new STREAMING_Y_IN from M+1.
- FINISH_FLAG rises before edge F: WR_EN high for the cycle after F (F+1). ADV is at F+2, and the next RD_REQ at F+3.
- Minimum per-block overhead: 4 cycles plus memory latency plus engine latency.
- DONE is high for exactly one cycle, coincident with the return to IDLE, with BUSY low in the same cycle.
- RST asserted mid-operation:
  - next edge is IDLE with all outputs at reset values;
  - no WR_EN is issued for the interrupted block;
  - position counters restart from 0.
- RD_VALID outside FETCH is ignored.
- FINISH_FLAG rises outside RUN are ignored, but finish_d still tracks the flag.

## Test plan
- Reset/idle: hold RST 3 cycles, then release with START=0 for 10 cycles → all outputs 0, BUSY=0.
- Full run, MODE=01, 1-cycle memory, engine returns lane k = slot+k 5 cycles after BLK_VALID:
  - 2×3600 WR_EN pulses;
  - WR_ADDR 0..3599 twice, WR_PASS 0 then 1;
  - COLUMNS wraps 79→0 with ROWS+1;
  - single DONE after the 7200th writeback.
- MODE=00 masking: RD_DATA all lanes 0xFFFF → STREAMING_Y_IN[2047:1024]=0 and [1023:0]=all 0xFFFF; WR_DATA upper half 0.
- FINISH_FLAG stuck high entering RUN: hold 20 cycles, drop 1 cycle, raise → exactly one WR_EN, 1 cycle after the rise is sampled.
- Timeout with TIMEOUT=16 and no FINISH_FLAG on slot 5 → ERROR=1, no WR_EN for slot 5, next RD_ADDR=6; illegal MODE=10 START → ERROR=1, BUSY stays 0.
- RST mid-RUN on slot 100, then START → RD_ADDR restarts at 0, no writeback for slot 100, ERROR=0.

Source files
------------

// File: rtl/memc_block_scheduler.sv
// memc_block_scheduler
//
// Block-level sequencer for the inter-prediction MEMC engine. Walks the
// BLK_COLS x BLK_ROWS grid of block slots in raster order for NUM_PASSES full
// passes per accepted start. For each slot it fetches the measurement vector
// from slot memory, presents it to the engine, waits for a rising edge on the
// engine's finish flag and writes the engine result back to reconstruction
// memory. A watchdog abandons a block whose engine never finishes.
//
// Ports
//   i_clk, i_rst          clock (rising edge) and synchronous active-high reset
//   i_start, i_mode       start pulse (honoured in idle only) and lane mode
//                         (00: lower half of lanes active, 01: all lanes)
//   o_rd_req, o_rd_addr   slot-memory read request and slot index
//   i_rd_valid, i_rd_data slot-memory read response
//   o_columns, o_rows     current block position to the engine
//   o_streaming_y_in      masked measurement vector to the engine
//   o_blk_valid           block presented to the engine (run state)
//   i_finish_flag         engine completion, rising edge used
//   i_streaming_y_out     engine result
//   o_wr_en, o_wr_addr,   one-cycle writeback strobe, slot index, pass LSB
//   o_wr_pass, o_wr_data  and masked engine result
//   o_busy, o_done        not idle / one-cycle end-of-job pulse
//   o_error               sticky error (illegal mode or engine timeout)

module memc_block_scheduler #(
   parameter int unsigned BLK_COLS   = 80,
   parameter int unsigned BLK_ROWS   = 45,
   parameter int unsigned LANES      = 128,
   parameter int unsigned DW         = 16,
   parameter int unsigned NUM_PASSES = 2,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [1:0]            i_mode,
   output logic                  o_rd_req,
   output logic [11:0]           o_rd_addr,
   input  logic                  i_rd_valid,
   input  logic [LANES*DW-1:0]   i_rd_data,
   output logic [7:0]            o_columns,
   output logic [7:0]            o_rows,
   output logic [LANES*DW-1:0]   o_streaming_y_in,
   output logic                  o_blk_valid,
   input  logic                  i_finish_flag,
   input  logic [LANES*DW-1:0]   i_streaming_y_out,
   output logic                  o_wr_en,
   output logic [11:0]           o_wr_addr,
   output logic                  o_wr_pass,
   output logic [LANES*DW-1:0]   o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int unsigned VW = LANES * DW;
   localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StRun,
      StWb,
      StAdv
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [7:0]      r_col;
   logic [7:0]      r_row;
   logic [PW-1:0]   r_pass;
   logic [11:0]     r_addr;
   logic            r_mode_wide;
   logic [VW-1:0]   r_y_in;
   logic [VW-1:0]   r_wr_data;
   logic            r_finish_d;
   logic [TW-1:0]   r_wdog;
   logic            r_error;
   logic            r_done;

   logic [VW-1:0]   w_mask;
   logic            w_rise;
   logic            w_timeout;
   logic            w_col_last;
   logic            w_row_last;
   logic            w_pass_last;
   logic            w_mode_legal;

   // Lane mask from the mode latched at start; inactive lanes read as zero
   // on both the engine input and the writeback data.
   always_comb begin
      w_mask = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (r_mode_wide || (k < LANES / 2)) begin
            w_mask[DW*k +: DW] = '1;
         end
      end
   end

   // A flag already high on run entry has r_finish_d set, so it is not a rise.
   assign w_rise       = i_finish_flag & ~r_finish_d;
   assign w_timeout    = (r_wdog == TW'(TIMEOUT - 1));
   assign w_col_last   = (r_col == 8'(BLK_COLS - 1));
   assign w_row_last   = (r_row == 8'(BLK_ROWS - 1));
   assign w_pass_last  = (r_pass == PW'(NUM_PASSES - 1));
   assign w_mode_legal = ~i_mode[1];

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start && w_mode_legal) begin
               w_state_next = StFetch;
            end
         end
         StFetch: begin
            if (i_rd_valid) begin
               w_state_next = StRun;
            end
         end
         StRun: begin
            if (w_rise) begin
               w_state_next = StWb;
            end else if (w_timeout) begin
               w_state_next = StAdv;
            end
         end
         StWb: begin
            w_state_next = StAdv;
         end
         StAdv: begin
            if (w_col_last && w_row_last && w_pass_last) begin
               w_state_next = StIdle;
            end else begin
               w_state_next = StFetch;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // State register and datapath
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_col       <= '0;
         r_row       <= '0;
         r_pass      <= '0;
         r_addr      <= '0;
         r_mode_wide <= 1'b0;
         r_y_in      <= '0;
         r_wr_data   <= '0;
         r_finish_d  <= 1'b0;
         r_wdog      <= '0;
         r_error     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_finish_d <= i_finish_flag;
         r_done     <= 1'b0;

         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (w_mode_legal) begin
                     r_col       <= '0;
                     r_row       <= '0;
                     r_pass      <= '0;
                     r_addr      <= '0;
                     r_error     <= 1'b0;
                     r_mode_wide <= i_mode[0];
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            StFetch: begin
               if (i_rd_valid) begin
                  r_y_in <= i_rd_data & w_mask;
                  r_wdog <= '0;
               end
            end
            StRun: begin
               if (w_rise) begin
                  r_wr_data <= i_streaming_y_out & w_mask;
               end else begin
                  r_wdog <= r_wdog + TW'(1);
                  if (w_timeout) begin
                     r_error <= 1'b1;
                  end
               end
            end
            StWb: begin
               // Writeback strobe is decoded from the state.
            end
            StAdv: begin
               if (w_col_last) begin
                  r_col <= '0;
                  if (w_row_last) begin
                     r_row  <= '0;
                     r_pass <= r_pass + PW'(1);
                     r_addr <= '0;
                     if (w_pass_last) begin
                        r_done <= 1'b1;
                     end
                  end else begin
                     r_row  <= r_row + 8'd1;
                     r_addr <= r_addr + 12'd1;
                  end
               end else begin
                  r_col  <= r_col + 8'd1;
                  r_addr <= r_addr + 12'd1;
               end
            end
            default: begin
               // Unreachable encodings fall back to idle via next-state logic.
            end
         endcase
      end
   end

   // Outputs
   assign o_rd_req         = (r_state == StFetch);
   assign o_rd_addr        = r_addr;
   assign o_columns        = r_col;
   assign o_rows           = r_row;
   assign o_streaming_y_in = r_y_in;
   assign o_blk_valid      = (r_state == StRun);
   assign o_wr_en          = (r_state == StWb);
   assign o_wr_addr        = r_addr;
   assign o_wr_pass        = r_pass[0];
   assign o_wr_data        = r_wr_data;
   assign o_busy           = (r_state != StIdle);
   assign o_done           = r_done;
   assign o_error          = r_error;

endmodule

// File: tb/tb_memc_block_scheduler.sv
// tb_memc_block_scheduler
//
// Self-checking bench for memc_block_scheduler on a reduced 10x12 grid with a
// short watchdog. Slot memory answers in one cycle with random data; the
// engine model returns lane k = slot + k a fixed latency after the block is
// presented. Monitors record fetches, presented blocks and writebacks; each
// test task compares those records against values derived from the raster
// walk (slot -> col/row/pass) and the lane-mode rules.

module tb_memc_block_scheduler;

   localparam int unsigned BLK_COLS   = 10;
   localparam int unsigned BLK_ROWS   = 12;
   localparam int unsigned LANES      = 128;
   localparam int unsigned DW         = 16;
   localparam int unsigned NUM_PASSES = 2;
   localparam int unsigned TIMEOUT    = 32;
   localparam int          SLOTS      = BLK_COLS * BLK_ROWS;
   localparam int          VW         = LANES * DW;
   localparam int          ENG_LAT    = 5;

   typedef logic [VW-1:0] vec_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        rd_valid = 1'b0;
   vec_t        rd_data = '0;
   logic        finish;
   vec_t        y_out = '0;

   logic        rd_req;
   logic [11:0] rd_addr;
   logic [7:0]  cols;
   logic [7:0]  rows;
   vec_t        y_in;
   logic        blk_valid;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic        wr_pass;
   vec_t        wr_data;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   memc_block_scheduler #(
      .BLK_COLS   (BLK_COLS),
      .BLK_ROWS   (BLK_ROWS),
      .LANES      (LANES),
      .DW         (DW),
      .NUM_PASSES (NUM_PASSES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_mode            (mode),
      .o_rd_req          (rd_req),
      .o_rd_addr         (rd_addr),
      .i_rd_valid        (rd_valid),
      .i_rd_data         (rd_data),
      .o_columns         (cols),
      .o_rows            (rows),
      .o_streaming_y_in  (y_in),
      .o_blk_valid       (blk_valid),
      .i_finish_flag     (finish),
      .i_streaming_y_out (y_out),
      .o_wr_en           (wr_en),
      .o_wr_addr         (wr_addr),
      .o_wr_pass         (wr_pass),
      .o_wr_data         (wr_data),
      .o_busy            (busy),
      .o_done            (done),
      .o_error           (error)
   );

   // ---------------- slot memory: one-cycle latency ----------------
   bit          mem_ones = 1'b0;
   logic [11:0] fq_addr[$];
   vec_t        fq_data[$];

   always @(negedge clk) begin
      if (rd_req) begin
         for (int k = 0; k < LANES; k++) begin
            rd_data[DW*k +: DW] = mem_ones ? 16'hFFFF : 16'($urandom);
         end
         rd_valid = 1'b1;
         fq_addr.push_back(rd_addr);
         fq_data.push_back(rd_data);
      end else begin
         rd_valid = 1'b0;
      end
   end

   // ---------------- engine model ----------------
   bit   eng_auto = 1'b1;
   logic man_finish = 1'b0;
   logic auto_finish = 1'b0;
   int   eng_skip = -1;
   int   eng_cnt = 0;
   int   eng_slot = 0;

   always @(negedge clk) begin
      eng_slot = int'(rows) * BLK_COLS + int'(cols);
      if (blk_valid) eng_cnt++;
      else eng_cnt = 0;
      for (int k = 0; k < LANES; k++) y_out[DW*k +: DW] = 16'(eng_slot + k);
      auto_finish = blk_valid && (eng_cnt >= ENG_LAT) && (eng_slot != eng_skip);
   end

   assign finish = eng_auto ? auto_finish : man_finish;

   // ---------------- monitors ----------------
   logic [11:0] wq_addr[$];
   logic        wq_pass[$];
   vec_t        wq_data[$];
   logic [7:0]  bq_col[$];
   logic [7:0]  bq_row[$];
   vec_t        bq_yin[$];
   int          bq_len[$];
   logic        prev_bv = 1'b0;
   int          bv_len = 0;
   int          done_cnt = 0;
   int          done_wr = 0;
   logic        done_busy = 1'b0;

   always @(negedge clk) begin
      if (wr_en) begin
         wq_addr.push_back(wr_addr);
         wq_pass.push_back(wr_pass);
         wq_data.push_back(wr_data);
      end
      if (blk_valid && !prev_bv) begin
         bq_col.push_back(cols);
         bq_row.push_back(rows);
         bq_yin.push_back(y_in);
         bv_len = 0;
      end
      if (blk_valid) bv_len++;
      if (!blk_valid && prev_bv) bq_len.push_back(bv_len);
      prev_bv = blk_valid;
      if (done) begin
         done_cnt++;
         done_wr   = wq_addr.size();
         done_busy = busy;
      end
   end

   // ---------------- reference helpers ----------------
   // Engine result for a slot as written back: lane k = slot + k, upper half
   // of lanes zero unless all lanes are active.
   function automatic vec_t exp_eng(input int slot, input bit wide);
      vec_t v;
      v = '0;
      for (int k = 0; k < LANES; k++) begin
         if (wide || k < LANES / 2) v[DW*k +: DW] = 16'(slot + k);
      end
      return v;
   endfunction

   function automatic vec_t lane_mask(input vec_t d, input bit wide);
      vec_t v;
      v = d;
      if (!wide) begin
         for (int k = LANES / 2; k < LANES; k++) v[DW*k +: DW] = '0;
      end
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] m);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({rd_req, blk_valid, wr_en, busy, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl cycle %0d got %b want 000000", c,
                     {rd_req, blk_valid, wr_en, busy, done, error});
         end
         checks++;
         if ({rd_addr, wr_addr, cols, rows, wr_pass} !== 41'b0) begin
            errors++;
            $display("FAIL reset_pos cycle %0d rd_addr %0d wr_addr %0d col %0d row %0d pass %0d",
                     c, rd_addr, wr_addr, cols, rows, wr_pass);
         end
         checks++;
         if (y_in !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_data cycle %0d y_in[63:0] %h wr_data[63:0] %h want 0",
                     c, y_in[63:0], wr_data[63:0]);
         end
      end
   endtask

   task automatic test_full_run();
      int wb, bb, fb, lb, db, n, slot;
      vec_t e;
      do_reset();
      wb = wq_addr.size(); bb = bq_col.size(); fb = fq_addr.size();
      lb = bq_len.size();  db = done_cnt;
      pulse_start(2'b01);
      checks++;
      if (busy !== 1'b1 || rd_req !== 1'b1 || rd_addr !== 12'd0) begin
         errors++;
         $display("FAIL start_latency busy %b rd_req %b rd_addr %0d want 1 1 0",
                  busy, rd_req, rd_addr);
      end
      n = 0;
      while (!done && n < 20000) begin @(negedge clk); n++; end
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL full_run_done_wait got timeout want DONE");
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt - db !== 1) begin
         errors++;
         $display("FAIL done_count got %0d want 1", done_cnt - db);
      end
      checks++;
      if (done_wr - wb !== 2 * SLOTS || done_busy !== 1'b0) begin
         errors++;
         $display("FAIL done_timing wr_before_done %0d busy %b want %0d 0",
                  done_wr - wb, done_busy, 2 * SLOTS);
      end
      checks++;
      if (wq_addr.size() - wb !== 2 * SLOTS) begin
         errors++;
         $display("FAIL wb_count got %0d want %0d", wq_addr.size() - wb, 2 * SLOTS);
      end
      for (int i = 0; i < 2 * SLOTS && wb + i < wq_addr.size(); i++) begin
         slot = i % SLOTS;
         e    = exp_eng(slot, 1'b1);
         checks++;
         if (wq_addr[wb+i] !== 12'(slot) || wq_pass[wb+i] !== 1'(i / SLOTS)) begin
            errors++;
            $display("FAIL wb_addr #%0d got addr %0d pass %0d want addr %0d pass %0d",
                     i, wq_addr[wb+i], wq_pass[wb+i], slot, i / SLOTS);
         end
         checks++;
         if (wq_data[wb+i] !== e) begin
            errors++;
            $display("FAIL wb_data #%0d got [63:0] %h want %h", i,
                     wq_data[wb+i][63:0], e[63:0]);
         end
      end
      for (int i = 0; i < 2 * SLOTS && bb + i < bq_col.size() && fb + i < fq_addr.size()
           && lb + i < bq_len.size(); i++) begin
         slot = i % SLOTS;
         checks++;
         if (bq_col[bb+i] !== 8'(slot % BLK_COLS) || bq_row[bb+i] !== 8'(slot / BLK_COLS)
             || fq_addr[fb+i] !== 12'(slot)) begin
            errors++;
            $display("FAIL blk_pos #%0d got col %0d row %0d rd_addr %0d want %0d %0d %0d",
                     i, bq_col[bb+i], bq_row[bb+i], fq_addr[fb+i],
                     slot % BLK_COLS, slot / BLK_COLS, slot);
         end
         checks++;
         if (bq_yin[bb+i] !== fq_data[fb+i] || bq_len[lb+i] !== ENG_LAT) begin
            errors++;
            $display("FAIL blk_present #%0d y_in[63:0] %h want %h run_cycles %0d want %0d",
                     i, bq_yin[bb+i][63:0], fq_data[fb+i][63:0], bq_len[lb+i], ENG_LAT);
         end
      end
   endtask

   task automatic test_mode00_mask();
      int n;
      vec_t e, hi, lo;
      do_reset();
      mem_ones = 1'b1;
      pulse_start(2'b00);
      mode = 2'b01;  // must be ignored until the next accepted start
      for (int b = 0; b < 2; b++) begin
         n = 0;
         while (!blk_valid && n < 100) begin @(negedge clk); n++; end
         hi = y_in >> (VW / 2);
         lo = y_in << (VW / 2);
         checks++;
         if (n >= 100 || hi !== '0 || lo !== {(VW/2){1'b1}} << (VW / 2)) begin
            errors++;
            $display("FAIL mask_y_in blk %0d hi[63:0] %h lo[63:0] %h want 0 and all ones",
                     b, hi[63:0], y_in[63:0]);
         end
         n = 0;
         while (!wr_en && n < 100) begin @(negedge clk); n++; end
         e  = exp_eng(b, 1'b0);
         hi = wr_data >> (VW / 2);
         checks++;
         if (n >= 100 || wr_data !== e || hi !== '0 || wr_addr !== 12'(b)) begin
            errors++;
            $display("FAIL mask_wr blk %0d addr %0d lanes[63:0] %h hi[63:0] %h want %0d %h 0",
                     b, wr_addr, wr_data[63:0], hi[63:0], b, e[63:0]);
         end
         @(negedge clk);
      end
      mem_ones = 1'b0;
      do_reset();
   endtask

   task automatic test_finish_stuck();
      int n, seen;
      do_reset();
      eng_auto   = 1'b0;
      man_finish = 1'b1;
      pulse_start(2'b01);
      n = 0;
      while (!blk_valid && n < 100) begin @(negedge clk); n++; end
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (wr_en) seen++;
         @(negedge clk);
      end
      man_finish = 1'b0;
      if (wr_en) seen++;
      @(negedge clk);
      man_finish = 1'b1;
      checks++;
      if (n >= 100 || seen !== 0 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL stuck_no_wb wr_en pulses %0d now %b want 0 0", seen, wr_en);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd0) begin
         errors++;
         $display("FAIL stuck_wb_timing wr_en %b addr %0d want 1 0", wr_en, wr_addr);
      end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (wr_en) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL stuck_single_wb extra pulses %0d want 0", seen);
      end
      man_finish = 1'b0;
      eng_auto   = 1'b1;
      do_reset();
   endtask

   task automatic test_timeout();
      int wb, lb, n, bad;
      do_reset();
      wb = wq_addr.size(); lb = bq_len.size();
      eng_skip = 5;
      pulse_start(2'b01);
      n = 0;
      while (!(rd_req && rd_addr == 12'd6) && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (n >= 500 || error !== 1'b1) begin
         errors++;
         $display("FAIL timeout_error got error %b wait %0d want 1", error, n);
      end
      @(negedge clk);
      bad = 0;
      for (int i = wb; i < wq_addr.size(); i++) if (wq_addr[i] == 12'd5) bad++;
      checks++;
      if (bad !== 0 || wq_addr.size() - wb !== 5) begin
         errors++;
         $display("FAIL timeout_no_wb slot5 writes %0d total %0d want 0 5",
                  bad, wq_addr.size() - wb);
      end
      checks++;
      if (lb + 5 >= bq_len.size() || bq_len[lb+5] !== TIMEOUT) begin
         errors++;
         $display("FAIL timeout_len got %0d want %0d",
                  (lb + 5 < bq_len.size()) ? bq_len[lb+5] : -1, TIMEOUT);
      end
      pulse_start(2'b00);  // busy: ignored, so ERROR stays set
      checks++;
      if (error !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_while_busy error %b busy %b want 1 1", error, busy);
      end
      eng_skip = -1;
      do_reset();
   endtask

   task automatic test_illegal_mode();
      do_reset();
      pulse_start(2'b10);
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0) begin
         errors++;
         $display("FAIL illegal_mode error %b busy %b rd_req %b want 1 0 0",
                  error, busy, rd_req);
      end
      pulse_start(2'b01);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL legal_start_clears error %b busy %b want 0 1", error, busy);
      end
      do_reset();
   endtask

   task automatic test_rst_mid_run();
      int wb, n;
      do_reset();
      pulse_start(2'b01);
      n = 0;
      while (!(blk_valid && int'(rows) * BLK_COLS + int'(cols) == 100) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      wb = wq_addr.size();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (n >= 3000 || {busy, wr_en, blk_valid, rd_req} !== 4'b0 || rd_addr !== 12'd0
          || cols !== 8'd0 || rows !== 8'd0 || y_in !== '0 || wr_data !== '0) begin
         errors++;
         $display("FAIL rst_mid_run busy %b wr_en %b bv %b addr %0d col %0d row %0d want 0",
                  busy, wr_en, blk_valid, rd_addr, cols, rows);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (wq_addr.size() - wb !== 0) begin
         errors++;
         $display("FAIL rst_no_wb got %0d writebacks want 0", wq_addr.size() - wb);
      end
      pulse_start(2'b01);
      checks++;
      if (rd_req !== 1'b1 || rd_addr !== 12'd0 || error !== 1'b0) begin
         errors++;
         $display("FAIL rst_restart rd_req %b addr %0d error %b want 1 0 0",
                  rd_req, rd_addr, error);
      end
      n = 0;
      while (!wr_en && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n >= 100 || wr_addr !== 12'd0) begin
         errors++;
         $display("FAIL rst_first_wb addr %0d want 0", wr_addr);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_mode00_mask();
      test_finish_stuck();
      test_timeout();
      test_illegal_mode();
      test_rst_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout got no completion want $finish");
      $fatal(1, "simulation time limit");
   end

endmodule
